// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared types and constants for the pattern sequence detector family
package seqdet_pkg;

  // Serializer control state
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int DEFAULT_WORD_W = 16;

endpackage : seqdet_pkg

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - double-buffered parallel-to-serial front end for the sequence detector
module seq_serializer
  import seqdet_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WORD_W,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clock_i,
  input  logic             areset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  input  logic             bit_ready_i,
  output logic             first_o,
  output logic             last_o,
  output logic             underrun_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] sh_next;

  // Handshake qualifiers; ready depends only on the hold flag, so no input reaches an output
  always_comb begin
    accept  = data_valid_i & ~hold_v_q;
    consume = (state_q == SHIFT) & bit_ready_i;
    if (MSB_FIRST != 0) begin
      sh_next = {sh_q[WIDTH-2:0], 1'b0};
    end else begin
      sh_next = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  // Next-state: load, shift, refill from hold or bypass, and park new words in hold
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    underrun_d = 1'b0;
    word_cnt_d = word_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = data_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (consume && (cnt_q == LAST_IDX)) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (hold_v_q) begin
            sh_d     = hold_q;
            hold_v_d = 1'b0;
            cnt_d    = '0;
          end else if (accept) begin
            // Zero-bubble bypass: the incoming word goes straight to the shifter
            sh_d  = data_i;
            cnt_d = '0;
          end else begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end else begin
          if (consume) begin
            sh_d  = sh_next;
            cnt_d = cnt_q + CW'(1);
          end
          if (accept) begin
            hold_d   = data_i;
            hold_v_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset discarding in-flight and held words
  always_ff @(posedge clock_i or posedge areset_i) begin
    if (areset_i) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      underrun_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      underrun_q <= underrun_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Outputs decoded from registered state only; serial outputs are quiet while idle
  always_comb begin
    data_ready_o = ~hold_v_q;
    bit_valid_o  = (state_q == SHIFT);
    bit_o        = (state_q == SHIFT) & sh_q[OUT_IDX];
    first_o      = (state_q == SHIFT) & (cnt_q == '0);
    last_o       = (state_q == SHIFT) & (cnt_q == LAST_IDX);
    underrun_o   = underrun_q;
    word_cnt_o   = word_cnt_q;
  end

endmodule : seq_serializer

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial front end for the pattern sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per consumed cycle on a serial stream with valid/ready.
- The stream feeds the detector's serial input; the detector ties bit_ready_i high.
- Double-buffered (shift register plus one holding register), so back-to-back words stream with no bubble.

Parameters:
- WIDTH, 16, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clock_i  in  1  single clock; all state updates on the rising edge.
- areset_i  in  1  asynchronous, active-high reset.
- data_i  in  WIDTH  parallel word.
- data_valid_i  in  1  data_i is valid.
- data_ready_o  out  1  block can accept a word; equals !hold_v.
- bit_o  out  1  current serial bit.
- bit_valid_o  out  1  bit_o is valid.
- bit_ready_i  in  1  consumer takes bit_o at this edge.
- first_o  out  1  bit_o is the first bit of a word.
- last_o  out  1  bit_o is the last bit of a word.
- underrun_o  out  1  one-cycle pulse: stream went idle after a word with no successor.
- word_cnt_o  out  CNT_W  count of fully consumed words; wraps modulo 2^CNT_W.

Behaviour:
- Registers: state {IDLE, SHIFT}, sh_q[WIDTH], cnt (0..WIDTH-1), hold_q[WIDTH], hold_v, underrun_q, word_cnt_q.
- Reset (async, areset_i=1): state=IDLE, cnt=0, hold_v=0, sh_q=0, hold_q=0, underrun_q=0, word_cnt_q=0.
- Reset output values: bit_valid_o=0, bit_o=0, first_o=0, last_o=0, underrun_o=0, word_cnt_o=0, data_ready_o=1.
- Accept: a word is taken at an edge where data_valid_i & data_ready_o.
- IDLE:
  - An accepted word loads sh_q; cnt=0; state=SHIFT.
  - Latency: first bit valid in the cycle after the accept edge.
- SHIFT, general:
  - bit_valid_o=1.
  - bit_o = sh_q[WIDTH-1] if MSB_FIRST, else sh_q[0].
  - first_o = (cnt==0); last_o = (cnt==WIDTH-1).
- SHIFT, accept while shifting: an accepted word goes to hold_q; hold_v=1.
- SHIFT, consume edge (bit_ready_i=1), cnt<WIDTH-1: shift sh_q toward the output end; cnt++.
- SHIFT, consume edge, cnt==WIDTH-1:
  - word_cnt_q++.
  - Then the first matching case applies:
  - (a) hold_v: sh_q<=hold_q, hold_v<=0, cnt<=0.
  - (b) !hold_v and accept at the same edge: sh_q<=data_i, cnt<=0. Zero-bubble bypass; hold stays empty.
  - (c) otherwise: state<=IDLE and underrun_q<=1 for exactly one cycle.
- SHIFT, bit_ready_i=0: sh_q, cnt, bit_o, first_o, last_o and bit_valid_o hold unchanged; acceptance into hold still allowed.
- Full: when hold_v=1, data_ready_o=0 until hold_q moves into the shifter. Input is never lost and never overwritten.
- underrun_o: registered; deasserts the next cycle unless condition (c) recurs.
- All outputs come from registers. There is no combinational path from any input to any output.
- Reset mid-word: the in-flight word and the held word are discarded. The next accepted word starts at its first bit.
- Counter wrap: word_cnt_o goes from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package seqdet_pkg:
  - state enum type ser_state_t {IDLE, SHIFT};
  - localparam DEFAULT_WORD_W=16, also used by detector benches.
- No sub-module is required. Shifter, hold register and counter stay in one module (about 150-200 lines).

Test Plan:
- Single word, defaults, 16'b1010110100110110 accepted, bit_ready_i=1 -> bit_o = 1,0,1,0,1,1,0,1,0,0,1,1,0,1,1,0 on 16 consecutive cycles from the cycle after accept; first_o on bit 1, last_o on bit 16; underrun_o pulses once the cycle after bit 16; word_cnt_o=1.
- Back-to-back: 16'hA5A5 then 16'h0F0F, both offered with data_valid_i held -> 32 contiguous bit_valid_o cycles with no gap; underrun_o only after bit 32; word_cnt_o=2.
- Hold-full: three words offered back-to-back -> data_ready_o=0 from the cycle after word 2 is accepted until the edge where word 1's last bit is consumed; all 48 bits emitted in order.
- Backpressure: bit_ready_i=0 for 3 cycles while bit 5 is presented -> bit_o, first_o and last_o frozen; word completes 19 cycles after its first bit; no bits lost or duplicated.
- Reset mid-word: areset_i pulsed after 7 bits of 16'hFFFF -> all outputs return to reset values immediately (async); next word 16'h8000 emits 1 followed by 15 zeros.
- MSB_FIRST=0, word 16'h0001 -> first emitted bit 1, then 15 zeros; 16'h8000 -> 15 zeros, then 1 with last_o=1.
